// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB2APB bridge: sequencer state encoding,
// APB slave address windows and one-hot peripheral select codes.
package apb_bridge_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // Each slave owns a 64 MiB window, packed contiguously from 0x8000_0000.
    localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
    localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
    localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
    localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

    localparam logic [2:0] PSEL_NONE = 3'b000;
    localparam logic [2:0] PSEL_SLV0 = 3'b001;
    localparam logic [2:0] PSEL_SLV1 = 3'b010;
    localparam logic [2:0] PSEL_SLV2 = 3'b100;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: maps an address onto one of the three APB
// slave windows, or reports a miss. Shared with the AHB slave side.
module apb_addr_decoder
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic [2:0]        o_psel
);

    always_comb begin
        // NOTE: outputs get defaults before any branch so no path leaves them unassigned (no latch).
        o_hit  = 1'b0;
        o_psel = PSEL_NONE;
        if (i_addr >= ADDR_W'(SLV0_BASE) && i_addr <= ADDR_W'(SLV0_LIMIT)) begin
            o_hit  = 1'b1;
            o_psel = PSEL_SLV0;
        end else if (i_addr >= ADDR_W'(SLV1_BASE) && i_addr <= ADDR_W'(SLV1_LIMIT)) begin
            o_hit  = 1'b1;
            o_psel = PSEL_SLV1;
        end else if (i_addr >= ADDR_W'(SLV2_BASE) && i_addr <= ADDR_W'(SLV2_LIMIT)) begin
            o_hit  = 1'b1;
            o_psel = PSEL_SLV2;
        end
    end

endmodule

// File: rtl/apb_transfer_sequencer.sv
// APB side of the AHB2APB bridge: takes single requests over valid/ready and
// runs SETUP->ACCESS with PREADY waits. Optional ACCESS timeout: APB_TIMEOUT_EN.
module apb_transfer_sequencer
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr,
    output logic [2:0]        psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [2:0]        r_psel;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_miss_pend;

    logic              w_hit;
    logic [2:0]        w_dec_psel;
    logic              w_accept;
    logic              w_done;
    logic              w_timeout;
    logic              w_idle_miss_rsp;
    logic              w_miss_pend_nxt;

    apb_addr_decoder #(
        .ADDR_W (ADDR_W)
    ) u_decoder (
        .i_addr (req_addr),
        .o_hit  (w_hit),
        .o_psel (w_dec_psel)
    );

    always_comb begin
        req_ready = 1'b0;
        case (r_state)
            ST_IDLE:   req_ready = 1'b1;
            ST_SETUP:  req_ready = 1'b0;
            ST_ACCESS: req_ready = pready;
            default:   req_ready = 1'b0;
        endcase
    end

    assign w_accept = req_valid && req_ready;
    assign w_done   = (r_state == ST_ACCESS) && pready;

`ifdef APB_TIMEOUT_EN
    logic [7:0] r_wait_cnt;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == ST_SETUP) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == ST_ACCESS && !pready) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive ACCESS cycle without pready.
    assign w_timeout = (r_state == ST_ACCESS) && !pready &&
                       (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT_CYCLES - 1);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_hit) w_state_nxt = ST_SETUP;
            end
            ST_SETUP: w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (w_done)         w_state_nxt = (w_accept && w_hit) ? ST_SETUP : ST_IDLE;
                else if (w_timeout) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_psel   <= PSEL_NONE;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else if (w_accept && w_hit) begin
            r_psel   <= w_dec_psel;
            r_pwrite <= req_write;
            r_paddr  <= req_addr;
            r_pwdata <= req_wdata;
        end
    end

    // A miss accepted on a completing ACCESS cycle is answered one cycle
    // after the normal response; r_miss_pend carries it across that gap.
    assign w_idle_miss_rsp = (r_state == ST_IDLE) && (r_miss_pend || (w_accept && !w_hit));
    assign w_miss_pend_nxt = w_accept && !w_hit &&
                             (w_done || ((r_state == ST_IDLE) && r_miss_pend));

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_miss_pend <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_done) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= pslverr;
                r_rsp_rdata <= r_pwrite ? '0 : prdata;
            end else if (w_timeout || w_idle_miss_rsp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= '0;
            end
            r_miss_pend <= w_miss_pend_nxt;
        end
    end

    assign psel      = (r_state == ST_SETUP || r_state == ST_ACCESS) ? r_psel : PSEL_NONE;
    assign penable   = (r_state == ST_ACCESS);
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_transfer_sequencer.sv
// Self-checking bench for apb_transfer_sequencer: directed and random requests
// against a transaction-level model of requests, APB transfers and responses.
module tb_apb_transfer_sequencer;

    localparam int TB_TIMEOUT = 4;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;

    always #5 Hclk = ~Hclk;

    apb_transfer_sequencer #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          waits;
        int          gap;
        bit          stuck;
    } req_t;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    int n_checks = 0;
    int n_errors = 0;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    int          gap_cnt  = 0;
    int          cyc      = 0;
    int          last_due = 0;
    bit          m_busy   = 1'b0;
    int          m_age    = 0;
    req_t        m_cur;
    logic [2:0]  m_sel    = 3'b000;
    logic [31:0] m_paddr  = '0;
    logic [31:0] m_pwdata = '0;
    logic        m_pwrite = 1'b0;
    logic        m_rsp_err   = 1'b0;
    logic [31:0] m_rsp_rdata = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Windows are 64 MiB each starting at 0x8000_0000; slave index = offset / 64 MiB.
    function automatic void model_decode(input logic [31:0] a, output bit hit, output logic [2:0] sel);
        int unsigned idx;
        hit = 1'b0;
        sel = 3'b000;
        if (a >= 32'h8000_0000 && a < 32'h8C00_0000) begin
            idx = (a - 32'h8000_0000) / 32'h0400_0000;
            hit = 1'b1;
            sel = 3'(1 << idx);
        end
    endfunction

    function automatic void add_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                    input logic [31:0] rd, input logic e, input int waits,
                                    input int gap, input bit stuck = 1'b0);
        req_t r;
        r.write = w; r.addr = a; r.wdata = wd; r.rdata = rd;
        r.err = e; r.waits = waits; r.gap = gap; r.stuck = stuck;
        if (req_q.size() == 0) gap_cnt = gap;
        req_q.push_back(r);
    endfunction

    function automatic void push_rsp(input logic e, input logic [31:0] rd);
        rsp_t r;
        r.due    = (cyc + 1 > last_due + 1) ? cyc + 1 : last_due + 1;
        r.err    = e;
        r.rdata  = rd;
        last_due = r.due;
        rsp_q.push_back(r);
    endfunction

    // One clock cycle: drive requester and APB slave from the model, check, advance the model.
    task automatic step();
        bit          in_access, completing, timing_out, exp_ready, accepted, hit, exp_valid;
        logic [2:0]  sel;
        req_t        nr;
        @(posedge Hclk);
        #1;
        in_access  = m_busy && m_age >= 2;
        completing = in_access && !m_cur.stuck && (m_age == 2 + m_cur.waits);
        timing_out = in_access && m_cur.stuck && (m_age == 1 + TB_TIMEOUT);
        if (in_access) begin
            pready  = completing;
            prdata  = completing ? m_cur.rdata : $urandom;
            pslverr = completing ? m_cur.err : 1'($urandom_range(0, 1));
        end else begin
            pready  = 1'($urandom_range(0, 1));
            prdata  = $urandom;
            pslverr = 1'($urandom_range(0, 1));
        end
        if (gap_cnt == 0 && req_q.size() > 0) begin
            req_valid = 1'b1;
            req_write = req_q[0].write;
            req_addr  = req_q[0].addr;
            req_wdata = req_q[0].wdata;
        end else begin
            req_valid = 1'b0;
            req_write = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            req_wdata = $urandom;
        end
        @(negedge Hclk);
        exp_ready = !m_busy || completing;
        check("req_ready", req_ready, exp_ready);
        check("psel", psel, m_busy ? m_sel : 3'b000);
        check("penable", penable, in_access);
        check("paddr", paddr, m_paddr);
        check("pwdata", pwdata, m_pwdata);
        check("pwrite", pwrite, m_pwrite);
        exp_valid = 1'b0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            exp_valid   = 1'b1;
            m_rsp_err   = rsp_q[0].err;
            m_rsp_rdata = rsp_q[0].rdata;
            void'(rsp_q.pop_front());
        end
        check("rsp_valid", rsp_valid, exp_valid);
        check("rsp_err", rsp_err, m_rsp_err);
        check("rsp_rdata", rsp_rdata, m_rsp_rdata);

        accepted = req_valid && exp_ready;
        if (completing) begin
            push_rsp(m_cur.err, m_cur.write ? 32'h0 : m_cur.rdata);
            m_busy = 1'b0;
        end
        if (timing_out) begin
            push_rsp(1'b1, 32'h0);
            m_busy = 1'b0;
        end
        if (accepted) begin
            nr = req_q.pop_front();
            model_decode(nr.addr, hit, sel);
            if (hit) begin
                m_busy   = 1'b1;
                m_cur    = nr;
                m_sel    = sel;
                m_age    = 0;
                m_paddr  = nr.addr;
                m_pwdata = nr.wdata;
                m_pwrite = nr.write;
            end else begin
                push_rsp(1'b1, 32'h0);
            end
            gap_cnt = (req_q.size() > 0) ? req_q[0].gap : 0;
        end else if (gap_cnt > 0) begin
            gap_cnt--;
        end
        if (m_busy) m_age++;
        cyc++;
    endtask

    task automatic run_until_drained(input int budget);
        int n = 0;
        while ((req_q.size() > 0 || m_busy || rsp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_within_budget", (n < budget), 1'b1);
    endtask

    task automatic reset_mid_access();
        int n = 0;
        add_req(1'b0, 32'h8400_0100, 32'h0, 32'h1234_5678, 1'b0, 6, 0);
        while (!(m_busy && m_age >= 3) && n < 50) begin
            step();
            n++;
        end
        check("reach_access", (n < 50), 1'b1);
        @(posedge Hclk);
        #1;
        pready    = 1'b0;
        req_valid = 1'b0;
        #2;
        Hresetn = 1'b0;
        #1;
        check("rst_psel", psel, 3'b000);
        check("rst_penable", penable, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_paddr", paddr, 32'h0);
        @(negedge Hclk);
        @(negedge Hclk);
        Hresetn = 1'b1;
        m_busy = 1'b0;
        rsp_q.delete();
        m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0; m_sel = 3'b000;
        m_rsp_err = 1'b0; m_rsp_rdata = '0;
        last_due = cyc;
        gap_cnt = (req_q.size() > 0) ? req_q[0].gap : 0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bnd [8] = '{32'h8000_0000, 32'h83FF_FFFF, 32'h8400_0000, 32'h87FF_FFFF,
                                 32'h8800_0000, 32'h8BFF_FFFF, 32'h8C00_0000, 32'h7FFF_FFFF};
        Hresetn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        #3;
        check("reset_psel", psel, 3'b000);
        check("reset_penable", penable, 1'b0);
        check("reset_pwrite", pwrite, 1'b0);
        check("reset_paddr", paddr, 32'h0);
        check("reset_pwdata", pwdata, 32'h0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", rsp_err, 1'b0);
        check("reset_req_ready", req_ready, 1'b1);
        @(negedge Hclk);
        @(negedge Hclk);
        Hresetn = 1'b1;

        // Directed: plain write, waited read, back-to-back, miss, slave error,
        // and a miss accepted on completion followed straight away by another miss.
        add_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 1);
        add_req(1'b0, 32'h8400_0004, 32'h0, 32'h0000_00A5, 1'b0, 3, 2);
        add_req(1'b1, 32'h8800_0000, 32'h1111_2222, 32'h0, 1'b0, 0, 2);
        add_req(1'b0, 32'h8000_0008, 32'h0, 32'h3C3C_5A5A, 1'b0, 0, 0);
        add_req(1'b0, 32'h9000_0000, 32'h0, 32'h0, 1'b0, 0, 2);
        add_req(1'b1, 32'h8000_0000, 32'hCAFE_F00D, 32'h0, 1'b1, 0, 2);
        add_req(1'b1, 32'h8000_0000, 32'h0000_0001, 32'h0, 1'b0, 0, 2);
        add_req(1'b0, 32'h8C00_0000, 32'h0, 32'h0, 1'b0, 0, 0);
        add_req(1'b0, 32'h7FFF_FFFF, 32'h0, 32'h0, 1'b0, 0, 0);
        add_req(1'b0, 32'h8BFF_FFFF, 32'h0, 32'h7777_8888, 1'b0, 1, 0);
        run_until_drained(200);

        reset_mid_access();
        run_until_drained(100);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            int unsigned pick;
            pick = $urandom_range(0, 9);
            if (pick == 0)      a = bnd[$urandom_range(0, 7)];
            else if (pick <= 2) a = $urandom;
            else                a = 32'h8000_0000 + 32'($urandom_range(0, 2)) * 32'h0400_0000
                                    + ($urandom & 32'h03FF_FFFF);
            add_req(1'($urandom_range(0, 1)), a, $urandom, $urandom,
                    1'($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3)));
        end
        run_until_drained(5000);

`ifdef APB_TIMEOUT_EN
        add_req(1'b0, 32'h8800_0040, 32'h0, 32'hFFFF_FFFF, 1'b0, 0, 1, 1'b1);
        add_req(1'b1, 32'h8000_0004, 32'h5555_AAAA, 32'h0, 1'b0, 0, 0);
        run_until_drained(100);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_transfer_sequencer.md
Name: apb_transfer_sequencer

Overview:
- Sequences the APB side of the AHB2APB bridge.
- Accepts single transfer requests from the AHB slave side through a valid/ready handshake.
- Decodes the address into one of three peripheral selects, then drives the APB SETUP→ACCESS protocol with PREADY wait states.
- Returns a registered response (read data, error) per transfer; its APB outputs feed the bridge's APB interface pass-through.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only when APB_TIMEOUT_EN is defined; legal range 1..255

Ports:
- Hclk  in  1  system clock, rising edge
- Hresetn  in  1  asynchronous active-low reset
- req_valid  in  1  transfer request present
- req_ready  out  1  request accepted this cycle (combinational from state/pready)
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  transfer address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  completion with error
- pready  in  1  APB slave ready
- prdata  in  DATA_W  APB read data
- pslverr  in  1  APB slave error
- psel  out  3  one-hot peripheral select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data

Behaviour:
- Reset (async, Hresetn=0): state IDLE; psel=000, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Reset mid-transfer aborts immediately with no response.
- Decode on req_addr:
  - 0x8000_0000–0x83FF_FFFF → psel 001
  - 0x8400_0000–0x87FF_FFFF → psel 010
  - 0x8800_0000–0x8BFF_FFFF → psel 100
  - anything else → miss
- States:
  - IDLE: req_ready=1.
    - On req_valid with a hit: register addr/wdata/write/psel and go to SETUP.
    - On req_valid with a miss: stay IDLE; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; no APB activity.
  - SETUP: psel=decoded, penable=0, req_ready=0; always ACCESS next cycle.
  - ACCESS: psel held, penable=1; paddr/pwdata/pwrite stable; req_ready=pready.
    - pready=0: remain in ACCESS.
    - pready=1: transfer completes. Next cycle rsp_valid=1, rsp_err=pslverr, rsp_rdata=prdata for reads (0 for writes).
    - Completion with req_valid and a hit: latch the new request, go straight to SETUP (back-to-back, no IDLE cycle); psel updates in that SETUP.
    - Completion with req_valid and a miss: go to IDLE. The miss error response follows one cycle after the normal response.
    - Otherwise go to IDLE; psel=000, penable=0.
- Latency: zero-wait transfer spends 1 cycle accepted + SETUP + ACCESS; rsp_valid arrives 3 cycles after acceptance.
- rsp_valid is a single-cycle pulse; rsp_rdata/rsp_err hold their last value until the next response.
- paddr/pwdata/pwrite hold their last values in IDLE; only psel/penable return to 0.
- pslverr and prdata are sampled only in ACCESS with pready=1.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: an 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0. When it reaches TIMEOUT_CYCLES:
  - drop psel/penable next cycle and go to IDLE;
  - rsp_valid=1, rsp_err=1, rsp_rdata=0;
  - a late pready is ignored.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Decomposition:
- Shared package apb_bridge_pkg:
  - state encoding IDLE/SETUP/ACCESS;
  - the three slave base/limit address constants;
  - psel one-hot constants.
- One sub-module, apb_addr_decoder: combinational addr → {hit, psel[2:0]}, reusable by the AHB slave side.

Test Plan:
- Write 0x8000_0010 data 0xDEAD_BEEF, pready=1 → SETUP psel=001 penable=0; ACCESS penable=1 pwrite=1; rsp_valid next cycle with err=0.
- Read 0x8400_0004, pready low 3 cycles then high with prdata=0xA5 → ACCESS lasts 4 cycles, psel=010; rsp_rdata=0xA5, err=0.
- Back-to-back: write 0x8800_0000 then read 0x8000_0008 held valid → second SETUP immediately follows first ACCESS; psel 100→001; two rsp_valid pulses 2 cycles apart.
- Unmapped read 0x9000_0000 → psel stays 000; rsp_valid=1, rsp_err=1, rsp_rdata=0 one cycle later.
- pslverr=1 with pready on a write to 0x8000_0000 → rsp_err=1. Hresetn low during ACCESS → psel=000, penable=0 immediately, no rsp_valid.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready stuck 0 → after 4 ACCESS cycles psel/penable drop; rsp_err=1; later pready=1 ignored.
